// File: rtl/imem_responder.sv
// Instruction-store responder: word reads/writes complete LATENCY cycles after acceptance.
// Latency: done pulses in cycle LATENCY after the accept cycle; stall covers cycles 1..LATENCY-1.
// Backpressure: requests are accepted only in IDLE or DONE; req seen while stall is high is ignored.
module imem_responder #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        done,
   output logic        stall,
   output logic        err
);

   localparam int         AW       = $clog2(DEPTH);
   localparam bit         LAT1     = (LATENCY == 1);
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic            unal_q, unal_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [15:0]     wdat_q, wdat_d;
   logic [15:0]     dout_q, dout_d;
   logic [15:0]     mem_q [DEPTH];

   logic            accept;
   logic            complete;
   logic            op_wr;
   logic            op_unal;
   logic [AW-1:0]   op_idx;
   logic [15:0]     op_dat;
   logic            mem_we;
   logic            unused_addr;

   assign unused_addr = ^addr[15:AW+1];

   // Gating with rst keeps a request held during reset from being taken.
   assign accept   = req && rst && (state_q == IDLE || state_q == DONE);
   assign complete = LAT1 ? accept : (state_q == BUSY && cnt_q == 4'd0);

   // With single-cycle latency the completing access is the one being accepted right now.
   always_comb begin
      op_wr   = LAT1 ? wr         : wr_q;
      op_unal = LAT1 ? addr[0]    : unal_q;
      op_idx  = LAT1 ? addr[AW:1] : idx_q;
      op_dat  = LAT1 ? data_in    : wdat_q;
      mem_we  = complete && op_wr && !op_unal;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = LAT1 ? DONE : BUSY;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done     = (state_q == DONE);
      stall    = (state_q == BUSY);
      err      = (state_q == DONE) && unal_q;
      data_out = dout_q;
   end

   always_comb begin
      wr_d   = wr_q;
      unal_d = unal_q;
      idx_d  = idx_q;
      wdat_d = wdat_q;
      if (accept) begin
         wr_d   = wr;
         unal_d = addr[0];
         idx_d  = addr[AW:1];
         wdat_d = data_in;
      end
   end

   always_comb begin
      dout_d = dout_q;
      if (complete && !op_wr) dout_d = op_unal ? 16'h0000 : mem_q[op_idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q   <= 1'b0;
         unal_q <= 1'b0;
         idx_q  <= '0;
         wdat_q <= 16'h0000;
         dout_q <= 16'h0000;
      end else begin
         wr_q   <= wr_d;
         unal_q <= unal_d;
         idx_q  <= idx_d;
         wdat_q <= wdat_d;
         dout_q <= dout_d;
      end
   end

   // Store contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[op_idx] <= op_dat;
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=4 instance (table, corner sequences, random ops) and LATENCY=1 instance.
module tb_imem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req4, wr4, done4, stall4, err4;
   logic [15:0] addr4, din4, dout4;
   logic        req1, wr1, done1, stall1, err1;
   logic [15:0] addr1, din1, dout1;

   imem_responder #(.LATENCY(4), .DEPTH(256)) dut (
      .clk(clk), .rst(rst), .req(req4), .wr(wr4), .addr(addr4), .data_in(din4),
      .data_out(dout4), .done(done4), .stall(stall4), .err(err4));

   imem_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .wr(wr1), .addr(addr1), .data_in(din1),
      .data_out(dout1), .done(done1), .stall(stall1), .err(err1));

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic        e_err;
      logic [15:0] e_dout;
   } vec_t;

   vec_t        tbl [15];
   logic [15:0] ref_mem [256];
   logic [15:0] m_dout;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One isolated access on the LATENCY=4 instance, starting from IDLE.
   task automatic op4(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic e_err, input logic [15:0] e_dout, input logic rel, input string tag);
      @(posedge clk); #1;
      if (rel) rst = 1'b1;
      req4 = 1'b1; wr4 = w; addr4 = a; din4 = d;
      @(negedge clk);
      chk({tag, ".stall0"}, 16'(stall4), 16'd0);
      @(posedge clk); #1;
      req4 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("%s.stall%0d", tag, k), 16'(stall4), 16'(k < 4));
         chk($sformatf("%s.done%0d", tag, k), 16'(done4), 16'(k == 4));
         if (k == 4) begin
            chk({tag, ".err"}, 16'(err4), 16'(e_err));
            chk({tag, ".dout"}, dout4, e_dout);
         end else begin
            chk($sformatf("%s.err%0d", tag, k), 16'(err4), 16'd0);
         end
      end
   endtask

   logic        w1 [16];
   logic [15:0] a1 [16];
   logic [15:0] d1 [16];
   logic        e_err1 [16];
   logic [15:0] e_dout1 [16];
   logic [15:0] m1_mem [256];
   logic [15:0] m1_dout;

   initial begin
      tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
      tbl[2]  = '{1'b1, 16'h0012, 16'h7777, 1'b0, 16'hBEEF};
      tbl[3]  = '{1'b1, 16'h0013, 16'hAAAA, 1'b1, 16'hBEEF};
      tbl[4]  = '{1'b0, 16'h0012, 16'h0000, 1'b0, 16'h7777};
      tbl[5]  = '{1'b0, 16'h0013, 16'h0000, 1'b1, 16'h0000};
      tbl[6]  = '{1'b1, 16'h0204, 16'h5A5A, 1'b0, 16'h0000};
      tbl[7]  = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'h5A5A};
      tbl[8]  = '{1'b1, 16'h0000, 16'h1111, 1'b0, 16'h5A5A};
      tbl[9]  = '{1'b1, 16'h0002, 16'h2222, 1'b0, 16'h5A5A};
      tbl[10] = '{1'b1, 16'h0020, 16'h3030, 1'b0, 16'h5A5A};
      tbl[11] = '{1'b0, 16'h0020, 16'h0000, 1'b0, 16'h3030};
      tbl[12] = '{1'b0, 16'h0204, 16'h0000, 1'b0, 16'h5A5A};
      tbl[13] = '{1'b1, 16'h01FE, 16'h0BAD, 1'b0, 16'h5A5A};
      tbl[14] = '{1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h0BAD};

      rst = 1'b0;
      req4 = 1'b0; wr4 = 1'b0; addr4 = 16'h0; din4 = 16'h0;
      req1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
      #12;
      chk("rst.dout4", dout4, 16'h0);
      chk("rst.done4", 16'(done4), 16'd0);
      chk("rst.stall4", 16'(stall4), 16'd0);
      chk("rst.err4", 16'(err4), 16'd0);
      chk("rst.dout1", dout1, 16'h0);
      chk("rst.done1", 16'(done1), 16'd0);
      chk("rst.stall1", 16'(stall1), 16'd0);
      chk("rst.err1", 16'(err1), 16'd0);
      @(negedge clk);

      // First row releases reset in the same cycle it requests.
      for (int i = 0; i < 15; i++)
         op4(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e_err, tbl[i].e_dout, (i == 0), $sformatf("tbl%0d", i));

      // Back-to-back reads: second request presented in the first one's done cycle.
      @(posedge clk); #1;
      req4 = 1'b1; wr4 = 1'b0; addr4 = 16'h0000;
      for (int t = 1; t <= 8; t++) begin
         @(posedge clk); #1;
         req4  = (t == 4);
         addr4 = (t >= 4) ? 16'h0002 : 16'h0000;
         @(negedge clk);
         chk($sformatf("b2b.stall%0d", t), 16'(stall4), 16'(t != 4 && t != 8));
         chk($sformatf("b2b.done%0d", t), 16'(done4), 16'(t == 4 || t == 8));
         if (t >= 4) chk($sformatf("b2b.dout%0d", t), dout4, (t == 8) ? 16'h2222 : 16'h1111);
      end

      // Reset in cycle 2 of a write aborts it.
      @(posedge clk); #1;
      req4 = 1'b1; wr4 = 1'b1; addr4 = 16'h0020; din4 = 16'h1234;
      @(posedge clk); #1;
      req4 = 1'b0;
      @(negedge clk);
      chk("abort.stall1", 16'(stall4), 16'd1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("abort.done", 16'(done4), 16'd0);
      chk("abort.stall", 16'(stall4), 16'd0);
      chk("abort.err", 16'(err4), 16'd0);
      chk("abort.dout", dout4, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      op4(1'b0, 16'h0020, 16'h0, 1'b0, 16'h3030, 1'b1, "abort.rd");

      // Requests raised during stall must not be taken.
      @(posedge clk); #1;
      req4 = 1'b1; wr4 = 1'b0; addr4 = 16'h0020;
      for (int t = 1; t <= 8; t++) begin
         @(posedge clk); #1;
         req4 = (t < 4);
         wr4 = 1'b1; din4 = 16'hFFFF;
         @(negedge clk);
         chk($sformatf("ign.stall%0d", t), 16'(stall4), 16'(t < 4));
         chk($sformatf("ign.done%0d", t), 16'(done4), 16'(t == 4));
         if (t == 4) chk("ign.dout", dout4, 16'h3030);
      end
      op4(1'b0, 16'h0020, 16'h0, 1'b0, 16'h3030, 1'b0, "ign.rd");

      // LATENCY=1: alternating write/read every cycle.
      m1_dout = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 0) begin
            w1[k] = 1'b1;
            a1[k] = 16'h0040 + 16'(2 * ((k / 2) % 2));
            if (k == 6) a1[k] = a1[k] | 16'h0001;
         end else begin
            w1[k] = 1'b0;
            a1[k] = 16'h0040 + 16'(2 * (((k - 1) / 2) % 2));
            if (k == 11) a1[k] = a1[k] | 16'h0001;
         end
         d1[k] = 16'($urandom);
         e_err1[k] = a1[k][0];
         if (!w1[k]) m1_dout = a1[k][0] ? 16'h0000 : m1_mem[a1[k][8:1]];
         else if (!a1[k][0]) m1_mem[a1[k][8:1]] = d1[k];
         e_dout1[k] = m1_dout;
      end
      for (int k = 0; k <= 16; k++) begin
         @(posedge clk); #1;
         if (k < 16) begin
            req1 = 1'b1; wr1 = w1[k]; addr1 = a1[k]; din1 = d1[k];
         end else begin
            req1 = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("l1.stall%0d", k), 16'(stall1), 16'd0);
         if (k == 0) begin
            chk("l1.done0", 16'(done1), 16'd0);
         end else begin
            chk($sformatf("l1.done%0d", k), 16'(done1), 16'd1);
            chk($sformatf("l1.err%0d", k), 16'(err1), 16'(e_err1[k-1]));
            chk($sformatf("l1.dout%0d", k), dout1, e_dout1[k-1]);
         end
      end
      @(negedge clk);
      chk("l1.idle", 16'(done1), 16'd0);

      // Random traffic against a word-array model; preload gives every word a defined value.
      m_dout = 16'h3030;
      for (int i = 0; i < 256; i++) begin
         logic [15:0] a, d;
         d = 16'($urandom);
         a = {7'($urandom), 8'(i), 1'b0};
         ref_mem[i] = d;
         op4(1'b1, a, d, 1'b0, m_dout, 1'b0, $sformatf("pre%0d", i));
      end
      for (int i = 0; i < 150; i++) begin
         logic        w;
         logic [15:0] a, d;
         w = 1'($urandom);
         a = 16'($urandom);
         d = 16'($urandom);
         if (!w) m_dout = a[0] ? 16'h0000 : ref_mem[a[8:1]];
         op4(w, a, d, a[0], m_dout, 1'b0, $sformatf("rnd%0d", i));
         if (w && !a[0]) ref_mem[a[8:1]] = d;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
